gate_tt_checker: RTL

- Response-side counterpart to the gate truth-table stimulus used in lab exercises.
- Drives every input combination into a combinational gate under test (GUT), waits a settle interval, and samples the GUT output.
- Compares each sample against an expected truth table and reports a pass/fail verdict, a per-vector error mask and an error count.
- Sits beside buf/xnor/nand-style GUTs so a run checks them automatically, replacing visual inspection of printed tables.

---
 rtl/gate_tt_if.sv | 27 ++
 rtl/gate_tt_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/gate_tt_if.sv
// Handshake and result bundle between a truth-table checker and whatever drives or observes it.
// The vector count is derived from NUM_INPUTS, so the checker and this interface must agree on it.
interface gate_tt_if #(
    parameter int NUM_INPUTS = 2
);
    localparam int V = 1 << NUM_INPUTS;

    logic                  start;
    logic [V-1:0]          expected;
    logic [NUM_INPUTS-1:0] vec_out;
    logic                  z_in;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [V-1:0]          err_mask;
    logic [NUM_INPUTS:0]   err_count;

    modport master (
        output start, expected, z_in,
        input  vec_out, busy, done, pass, err_mask, err_count
    );

    modport slave (
        input  start, expected, z_in,
        output vec_out, busy, done, pass, err_mask, err_count
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Walks a combinational gate through every input vector and compares its output with a truth table.
// Each vector is held SETTLE_CYCLES+1 edges and sampled on the last one; results are published with done.
//
//   state | meaning
//   IDLE  | waiting for start; previous run's verdict held on the outputs
//   HOLD  | driving vec_out and counting out its settle window
//   DONE  | one-cycle done pulse; published verdict is already valid here
module gate_tt_checker #(
    parameter int NUM_INPUTS    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input logic     clk,
    input logic     rst_n,
    gate_tt_if.slave bus
);
    localparam int V  = 1 << NUM_INPUTS;
    localparam int CW = NUM_INPUTS + 1;

    localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES);
    localparam logic [NUM_INPUTS-1:0] VEC_LAST    = '1;
    localparam logic [NUM_INPUTS-1:0] VEC_ONE     = NUM_INPUTS'(1);
    localparam logic [CW-1:0]         CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]         CNT_MAX     = CW'(V);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_INPUTS-1:0] vec_q, vec_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [V-1:0]          exp_q, exp_d;
    logic [V-1:0]          wmask_q, wmask_d;
    logic [CW-1:0]         wcount_q, wcount_d;
    logic [V-1:0]          mask_q, mask_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pass_q, pass_d;

    logic                  mis;
    logic [V-1:0]          mask_upd;
    logic [CW-1:0]         count_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            wmask_q  <= '0;
            wcount_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            wmask_q  <= wmask_d;
            wcount_q <= wcount_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        wmask_d   = wmask_q;
        wcount_d  = wcount_q;
        mask_d    = mask_q;
        count_d   = count_q;
        pass_d    = pass_q;
        mis       = 1'b0;
        mask_upd  = wmask_q;
        count_upd = wcount_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = HOLD;
                    exp_d    = bus.expected;
                    wmask_d  = '0;
                    wcount_d = '0;
                    vec_d    = '0;
                    cnt_d    = '0;
                end
            end
            HOLD: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    mis   = (bus.z_in != exp_q[vec_q]);
                    if (mis) begin
                        mask_upd[vec_q] = 1'b1;
                        if (wcount_q != CNT_MAX) begin
                            count_upd = wcount_q + CNT_ONE;
                        end
                    end
                    wmask_d  = mask_upd;
                    wcount_d = count_upd;
                    // Publish on entry to DONE so the verdict is valid in the same cycle as done.
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                        mask_d  = mask_upd;
                        count_d = count_upd;
                        pass_d  = (count_upd == '0);
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.vec_out   = vec_q;
    assign bus.busy      = (state_q == HOLD);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.err_mask  = mask_q;
    assign bus.err_count = count_q;
endmodule
